pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Instruction-fetch controller for the 16-bit program counter register. It owns the PC register's `write`/`data` inputs and derives the fetch address from the register's `pc_plus_one` output. It also runs the request/acknowledge handshake with instruction memory and presents fetched words to decode with a valid/ready handshake. It applies branch redirects and takes a single-level interrupt at instruction boundaries.

## Interface
- `RESET_VECTOR`, 16'h0000, first PC loaded after reset
- `IRQ_VECTOR`, 16'h0010, PC loaded when an interrupt is taken

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc_plus_one`  in  16  PC+1 from the PC register
- `pc_data`  out  16  next-PC value to the PC register
- `pc_write`  out  1  PC register write enable
- `mem_req`  out  1  fetch request
- `mem_addr`  out  16  fetch address, equal to `pc_plus_one - 1` (mod 2^16)
- `mem_ack`  in  1  memory acknowledge; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  16  fetched word
- `instr`  out  16  registered instruction to decode
- `instr_valid`  out  1  `instr` is valid
- `instr_ready`  in  1  decode accepts `instr`
- `branch_valid`  in  1  one-cycle redirect pulse from execute
- `branch_target`  in  16  redirect address
- `irq`  in  1  level interrupt request
- `ie_set`  in  1  pulse that sets the interrupt-enable bit
- `epc`  out  16  return PC saved when an interrupt is taken
- `irq_ack`  out  1  one-cycle pulse when an interrupt is taken

## Operation
- Internal registers: `state` (RESET, FETCH, ISSUE, SQUASH, VECTOR), `instr`, `epc`, `ie`, and `redir` (16 bits).
- **RESET**
  - Drive `pc_write=1`, `pc_data=RESET_VECTOR`.
  - Go to FETCH.
- **FETCH**
  - Drive `mem_req=1`.
  - Hold `mem_req` and `mem_addr` stable until `mem_ack`.
  - On `mem_ack`: `instr<=mem_rdata`, go to ISSUE.
  - `branch_valid` without `mem_ack`: `redir<=branch_target`, go to SQUASH.
  - `branch_valid` with `mem_ack`: drive `pc_write=1`, `pc_data=branch_target`; discard the fetched word; stay in FETCH.
- **SQUASH**
  - Drive `mem_req=1`.
  - On `mem_ack`: discard the data, drive `pc_write=1`, `pc_data=redir`, go to FETCH.
  - A further `branch_valid` overwrites `redir`. If it arrives in the `mem_ack` cycle, write `branch_target` directly.
- **ISSUE**
  - Drive `instr_valid=1`. `instr` stays stable until accepted.
  - `branch_valid` has priority over the handshake. Drive `pc_write=1`, `pc_data=branch_target`, drop `instr_valid` next cycle, go to FETCH. `instr` is not counted as accepted.
  - Otherwise, on `instr_ready`, drive `pc_write=1`, `pc_data=pc_plus_one`.
    - If `irq & ie`: `epc<=pc_plus_one`, go to VECTOR.
    - Otherwise go to FETCH.
- **VECTOR**
  - Drive `pc_write=1`, `pc_data=IRQ_VECTOR`, `irq_ack=1`.
  - `ie<=0`.
  - Go to FETCH.
- `ie`:
  - Set by `ie_set` in any state.
  - Cleared in VECTOR; the clear wins over a simultaneous `ie_set`.
- Interrupts are sampled only at the ISSUE accept edge. `irq` asserted between boundaries waits for the next one.
- Address arithmetic is 16-bit modulo:
  - `pc_plus_one` of 16'hFFFF is 16'h0000.
  - `mem_addr` for PC=16'hFFFF is 16'hFFFF.
- `pc_write` is asserted only in the cases listed above. When it is low, `pc_data` = 0.

## Timing
- Reset values, forced immediately on `rst` assertion without waiting for `clk`:
  - `state` = RESET.
  - `pc_write`, `pc_data`, `mem_req`, `instr`, `instr_valid`, `epc`, `ie`, `irq_ack`, `redir` are all 0.
  - An in-flight fetch is abandoned; memory must tolerate `mem_req` dropping before `mem_ack`.
- First rising edge after `rst` deasserts: the RESET_VECTOR write happens. `mem_req` rises in the next cycle.
- PC writes take effect at the same edge that leaves the state. `mem_addr` in the following FETCH cycle reflects the new PC.
- `mem_ack` may arrive in the same cycle `mem_req` rises (zero wait).
- Fetch-to-issue latency: `instr_valid` is high in the cycle after `mem_ack`.
- Best-case throughput: one instruction per 2 cycles (FETCH, ISSUE).
- A taken interrupt adds one cycle (VECTOR) before the vector fetch.
- `irq_ack` is a single-cycle pulse, coincident with the IRQ_VECTOR write.

## Test plan
- **Reset:** pulse `rst` asynchronously mid-cycle during FETCH → outputs 0 immediately. After release, `pc_write=1`, `pc_data`=16'h0000 for one cycle, then `mem_req=1`, `mem_addr`=16'h0000.
- **Sequential fetch:** `mem_ack` and `instr_ready` tied high, memory returns the address as data → `instr` = 0, 1, 2, … on `instr_valid` every second cycle; `mem_addr` 16'hFFFF is followed by 16'h0000.
- **Backpressure and wait states:**
  - Hold `instr_ready` low for 5 cycles → `instr_valid` and `instr` stay stable, no `pc_write`.
  - Delay `mem_ack` 3 cycles → `mem_req` and `mem_addr` stay stable.
- **Branch:**
  - `branch_valid` with target 16'h0040 during ISSUE → no accept; next `mem_addr`=16'h0040.
  - Same during FETCH with `mem_ack` delayed 2 cycles → the stale word is never presented; next `mem_addr`=16'h0040.
- **Interrupt:**
  - `ie_set`, then `irq=1` while the instruction at 16'h0007 is accepted → `epc`=16'h0008, `irq_ack` pulse, next `mem_addr`=16'h0010, `ie`=0.
  - A second `irq` is ignored until `ie_set`.
- **Simultaneous events:** `branch_valid` and `instr_ready` in the same ISSUE cycle with `irq&ie` → branch wins: `pc_data`=target, no `irq_ack`, `epc` unchanged.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction memory and decode handshake bundle for pc_sequencer
interface pc_sequencer_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output mem_req, mem_addr, instr, instr_valid,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_valid,
        output mem_ack, mem_rdata, instr_ready
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-fetch controller driving the PC register, memory fetch and decode issue
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] IRQ_VECTOR   = 16'h0010
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.master bus,
    input  logic [15:0]   pc_plus_one,
    output logic [15:0]   pc_data,
    output logic          pc_write,
    input  logic          branch_valid,
    input  logic [15:0]   branch_target,
    input  logic          irq,
    input  logic          ie_set,
    output logic [15:0]   epc,
    output logic          irq_ack
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_ISSUE,
        S_SQUASH,
        S_VECTOR
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] instr_q, instr_nxt;
    logic [15:0] epc_q, epc_nxt;
    logic [15:0] redir_q, redir_nxt;
    logic        ie_q, ie_nxt;

    logic        pc_write_c;
    logic [15:0] pc_data_c;
    logic        mem_req_c;
    logic        instr_valid_c;
    logic        irq_ack_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_RESET;
            instr_q <= 16'h0000;
            epc_q   <= 16'h0000;
            redir_q <= 16'h0000;
            ie_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            instr_q <= instr_nxt;
            epc_q   <= epc_nxt;
            redir_q <= redir_nxt;
            ie_q    <= ie_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        instr_nxt     = instr_q;
        epc_nxt       = epc_q;
        redir_nxt     = redir_q;
        ie_nxt        = ie_q | ie_set;
        pc_write_c    = 1'b0;
        pc_data_c     = 16'h0000;
        mem_req_c     = 1'b0;
        instr_valid_c = 1'b0;
        irq_ack_c     = 1'b0;

        case (state)
            S_RESET: begin
                pc_write_c = 1'b1;
                pc_data_c  = RESET_VECTOR;
                state_nxt  = S_FETCH;
            end

            S_FETCH: begin
                mem_req_c = 1'b1;
                if (bus.mem_ack) begin
                    // A redirect in the ack cycle drops the returned word and refetches at once.
                    if (branch_valid) begin
                        pc_write_c = 1'b1;
                        pc_data_c  = branch_target;
                    end else begin
                        instr_nxt = bus.mem_rdata;
                        state_nxt = S_ISSUE;
                    end
                end else if (branch_valid) begin
                    redir_nxt = branch_target;
                    state_nxt = S_SQUASH;
                end
            end

            S_SQUASH: begin
                // The outstanding request must complete before the PC can move.
                mem_req_c = 1'b1;
                if (bus.mem_ack) begin
                    pc_write_c = 1'b1;
                    pc_data_c  = branch_valid ? branch_target : redir_q;
                    state_nxt  = S_FETCH;
                end else if (branch_valid) begin
                    redir_nxt = branch_target;
                end
            end

            S_ISSUE: begin
                instr_valid_c = 1'b1;
                if (branch_valid) begin
                    pc_write_c = 1'b1;
                    pc_data_c  = branch_target;
                    state_nxt  = S_FETCH;
                end else if (bus.instr_ready) begin
                    pc_write_c = 1'b1;
                    pc_data_c  = pc_plus_one;
                    if (irq && ie_q) begin
                        epc_nxt   = pc_plus_one;
                        state_nxt = S_VECTOR;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end

            S_VECTOR: begin
                pc_write_c = 1'b1;
                pc_data_c  = IRQ_VECTOR;
                irq_ack_c  = 1'b1;
                ie_nxt     = 1'b0;
                state_nxt  = S_FETCH;
            end

            default: begin
                state_nxt = S_RESET;
            end
        endcase
    end

    // Combinational outputs are masked by rst so they fall without waiting for a clock.
    assign pc_write        = pc_write_c & ~rst;
    assign pc_data         = rst ? 16'h0000 : pc_data_c;
    assign irq_ack         = irq_ack_c & ~rst;
    assign bus.mem_req     = mem_req_c & ~rst;
    assign bus.instr_valid = instr_valid_c & ~rst;
    assign bus.mem_addr    = pc_plus_one - 16'd1;
    assign bus.instr       = instr_q;
    assign epc             = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_reg = 16'h1234;
    logic [15:0] pc_plus_one;
    logic [15:0] pc_data;
    logic        pc_write;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic        irq;
    logic        ie_set;
    logic [15:0] epc;
    logic        irq_ack;

    int n_cmp = 0;
    int n_err = 0;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .pc_plus_one   (pc_plus_one),
        .pc_data       (pc_data),
        .pc_write      (pc_write),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .irq           (irq),
        .ie_set        (ie_set),
        .epc           (epc),
        .irq_ack       (irq_ack)
    );

    always #5 clk = ~clk;

    // PC register model and a memory that returns the address as data
    always @(posedge clk) if (pc_write) pc_reg <= pc_data;
    assign pc_plus_one   = pc_reg + 16'd1;
    assign bus.mem_rdata = bus.mem_addr;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (pc_write !== 1'b0)        begin n_err++; $display("FAIL rst_pc_write got %b exp 0", pc_write); end
        n_cmp++; if (pc_data !== 16'h0000)     begin n_err++; $display("FAIL rst_pc_data got %h exp 0000", pc_data); end
        n_cmp++; if (bus.mem_req !== 1'b0)     begin n_err++; $display("FAIL rst_mem_req got %b exp 0", bus.mem_req); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_instr_valid got %b exp 0", bus.instr_valid); end
        n_cmp++; if (bus.instr !== 16'h0000)   begin n_err++; $display("FAIL rst_instr got %h exp 0000", bus.instr); end
        n_cmp++; if (epc !== 16'h0000)         begin n_err++; $display("FAIL rst_epc got %h exp 0000", epc); end
        n_cmp++; if (irq_ack !== 1'b0)         begin n_err++; $display("FAIL rst_irq_ack got %b exp 0", irq_ack); end
        tick;
        rst = 1'b0;
        #1;
        n_cmp++; if (pc_write !== 1'b1 || pc_data !== 16'h0000) begin n_err++; $display("FAIL rst_vector_write got %b/%h exp 1/0000", pc_write, pc_data); end
        tick;
        n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL rst_write_once got %b exp 0", pc_write); end
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_first_fetch got %b/%h exp 1/0000", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_sequential;
        bus.mem_ack = 1'b1;
        bus.instr_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'(i)) begin n_err++; $display("FAIL seq_addr got %b/%h exp 1/%h", bus.mem_req, bus.mem_addr, 16'(i)); end
            tick;
            n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'(i)) begin n_err++; $display("FAIL seq_instr got %b/%h exp 1/%h", bus.instr_valid, bus.instr, 16'(i)); end
            n_cmp++; if (pc_write !== 1'b1 || pc_data !== 16'(i + 1)) begin n_err++; $display("FAIL seq_pc got %b/%h exp 1/%h", pc_write, pc_data, 16'(i + 1)); end
            tick;
        end
    endtask

    task automatic test_wrap;
        tick;
        branch_valid = 1'b1;
        branch_target = 16'hFFFF;
        #1;
        n_cmp++; if (pc_write !== 1'b1 || pc_data !== 16'hFFFF) begin n_err++; $display("FAIL wrap_branch got %b/%h exp 1/ffff", pc_write, pc_data); end
        tick;
        branch_valid = 1'b0;
        #1;
        n_cmp++; if (bus.mem_addr !== 16'hFFFF || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL wrap_addr_ffff got %h/%b exp ffff/0", bus.mem_addr, bus.instr_valid); end
        tick;
        n_cmp++; if (bus.instr !== 16'hFFFF || pc_data !== 16'h0000) begin n_err++; $display("FAIL wrap_pc_next got %h/%h exp ffff/0000", bus.instr, pc_data); end
        tick;
        n_cmp++; if (bus.mem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr_0 got %h exp 0000", bus.mem_addr); end
    endtask

    task automatic test_backpressure;
        bus.instr_ready = 1'b0;
        tick;
        bus.mem_ack = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h0000 || pc_write !== 1'b0) begin n_err++; $display("FAIL bp_hold got %b/%h/%b exp 1/0000/0", bus.instr_valid, bus.instr, pc_write); end
            tick;
        end
        bus.instr_ready = 1'b1;
        #1;
        n_cmp++; if (pc_write !== 1'b1 || pc_data !== 16'h0001) begin n_err++; $display("FAIL bp_accept got %b/%h exp 1/0001", pc_write, pc_data); end
        tick;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0001 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL ws_hold got %b/%h/%b exp 1/0001/0", bus.mem_req, bus.mem_addr, bus.instr_valid); end
            tick;
        end
        bus.mem_ack = 1'b1;
        tick;
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h0001) begin n_err++; $display("FAIL ws_instr got %b/%h exp 1/0001", bus.instr_valid, bus.instr); end
        tick;
    endtask

    task automatic test_branch_issue;
        tick;
        branch_valid = 1'b1;
        branch_target = 16'h0040;
        #1;
        n_cmp++; if (pc_write !== 1'b1 || pc_data !== 16'h0040) begin n_err++; $display("FAIL bri_pc got %b/%h exp 1/0040", pc_write, pc_data); end
        tick;
        branch_valid = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b0 || bus.mem_addr !== 16'h0040) begin n_err++; $display("FAIL bri_next got %b/%h exp 0/0040", bus.instr_valid, bus.mem_addr); end
    endtask

    task automatic test_branch_fetch;
        tick;
        tick;
        bus.mem_ack = 1'b0;
        branch_valid = 1'b1;
        branch_target = 16'h0040;
        #1;
        n_cmp++; if (bus.mem_addr !== 16'h0041 || pc_write !== 1'b0) begin n_err++; $display("FAIL brf_nowrite got %h/%b exp 0041/0", bus.mem_addr, pc_write); end
        tick;
        branch_valid = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL brf_squash got %b/%b exp 1/0", bus.mem_req, bus.instr_valid); end
        tick;
        bus.mem_ack = 1'b1;
        #1;
        n_cmp++; if (pc_write !== 1'b1 || pc_data !== 16'h0040 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL brf_redir got %b/%h/%b exp 1/0040/0", pc_write, pc_data, bus.instr_valid); end
        tick;
        bus.mem_ack = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b0 || bus.mem_addr !== 16'h0040) begin n_err++; $display("FAIL brf_next got %b/%h exp 0/0040", bus.instr_valid, bus.mem_addr); end
        bus.mem_ack = 1'b1;
        tick;
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h0040) begin n_err++; $display("FAIL brf_instr got %b/%h exp 1/0040", bus.instr_valid, bus.instr); end
        tick;
        branch_valid = 1'b1;
        branch_target = 16'h0007;
        #1;
        n_cmp++; if (pc_write !== 1'b1 || pc_data !== 16'h0007) begin n_err++; $display("FAIL brf_ack_pc got %b/%h exp 1/0007", pc_write, pc_data); end
        tick;
        branch_valid = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b0 || bus.mem_addr !== 16'h0007) begin n_err++; $display("FAIL brf_ack_next got %b/%h exp 0/0007", bus.instr_valid, bus.mem_addr); end
    endtask

    task automatic test_interrupt;
        ie_set = 1'b1;
        irq = 1'b1;
        tick;
        ie_set = 1'b0;
        #1;
        n_cmp++; if (bus.instr !== 16'h0007 || pc_data !== 16'h0008 || irq_ack !== 1'b0) begin n_err++; $display("FAIL irq_accept got %h/%h/%b exp 0007/0008/0", bus.instr, pc_data, irq_ack); end
        tick;
        n_cmp++; if (pc_write !== 1'b1 || pc_data !== 16'h0010 || irq_ack !== 1'b1) begin n_err++; $display("FAIL irq_vector got %b/%h/%b exp 1/0010/1", pc_write, pc_data, irq_ack); end
        n_cmp++; if (epc !== 16'h0008) begin n_err++; $display("FAIL irq_epc got %h exp 0008", epc); end
        tick;
        n_cmp++; if (irq_ack !== 1'b0 || bus.mem_addr !== 16'h0010) begin n_err++; $display("FAIL irq_fetch got %b/%h exp 0/0010", irq_ack, bus.mem_addr); end
        tick;
        tick;
        n_cmp++; if (irq_ack !== 1'b0 || bus.mem_addr !== 16'h0011 || epc !== 16'h0008) begin n_err++; $display("FAIL irq_masked got %b/%h/%h exp 0/0011/0008", irq_ack, bus.mem_addr, epc); end
        ie_set = 1'b1;
        tick;
        ie_set = 1'b0;
        tick;
        n_cmp++; if (irq_ack !== 1'b1 || epc !== 16'h0012) begin n_err++; $display("FAIL irq_second got %b/%h exp 1/0012", irq_ack, epc); end
        ie_set = 1'b1;
        tick;
        ie_set = 1'b0;
        tick;
        tick;
        n_cmp++; if (irq_ack !== 1'b0 || bus.mem_addr !== 16'h0011) begin n_err++; $display("FAIL irq_clear_wins got %b/%h exp 0/0011", irq_ack, bus.mem_addr); end
    endtask

    task automatic test_simultaneous;
        ie_set = 1'b1;
        tick;
        ie_set = 1'b0;
        branch_valid = 1'b1;
        branch_target = 16'h0080;
        #1;
        n_cmp++; if (pc_write !== 1'b1 || pc_data !== 16'h0080 || irq_ack !== 1'b0) begin n_err++; $display("FAIL sim_branch got %b/%h/%b exp 1/0080/0", pc_write, pc_data, irq_ack); end
        tick;
        branch_valid = 1'b0;
        irq = 1'b0;
        bus.mem_ack = 1'b0;
        #1;
        n_cmp++; if (irq_ack !== 1'b0 || bus.mem_addr !== 16'h0080 || epc !== 16'h0012) begin n_err++; $display("FAIL sim_after got %b/%h/%h exp 0/0080/0012", irq_ack, bus.mem_addr, epc); end
    endtask

    task automatic test_async_reset;
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || pc_write !== 1'b0) begin n_err++; $display("FAIL arst_outputs got %b/%b exp 0/0", bus.mem_req, pc_write); end
        n_cmp++; if (bus.instr !== 16'h0000 || epc !== 16'h0000) begin n_err++; $display("FAIL arst_regs got %h/%h exp 0000/0000", bus.instr, epc); end
        tick;
        rst = 1'b0;
        #1;
        n_cmp++; if (pc_write !== 1'b1 || pc_data !== 16'h0000) begin n_err++; $display("FAIL arst_vector got %b/%h exp 1/0000", pc_write, pc_data); end
        tick;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0000) begin n_err++; $display("FAIL arst_fetch got %b/%h exp 1/0000", bus.mem_req, bus.mem_addr); end
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        branch_valid = 1'b0;
        branch_target = 16'h0000;
        irq = 1'b0;
        ie_set = 1'b0;
        test_reset;
        test_sequential;
        test_wrap;
        test_backpressure;
        test_branch_issue;
        test_branch_fetch;
        test_interrupt;
        test_simultaneous;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
